// File: rtl/bsg_manycore_fsb_tx_sched.sv
// Credit-gated round-robin scheduler that feeds one FSB ring output register
// from num_chan_p requesting channels.
module bsg_manycore_fsb_tx_sched #(
  parameter int unsigned ring_width_p     = 80,
  parameter int unsigned num_chan_p       = 4,
  parameter int unsigned remote_credits_p = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_chan_p-1:0]              ch_v_i,
  input  logic [num_chan_p*ring_width_p-1:0] ch_data_i,
  output logic [num_chan_p-1:0]              ch_yumi_o,
  input  logic [num_chan_p-1:0]              credit_v_i,
  output logic                               v_o,
  output logic [ring_width_p-1:0]            data_o,
  input  logic                               yumi_i,
  output logic                               credit_err_o
);

  localparam int unsigned CntW = $clog2(remote_credits_p + 1);
  localparam int unsigned PtrW = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(remote_credits_p);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(num_chan_p - 1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                  state_q, state_d;
  logic [ring_width_p-1:0] data_q, data_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [CntW-1:0]         cnt_q [num_chan_p];
  logic [CntW-1:0]         cnt_d [num_chan_p];
  logic                    err_q, err_d;

  logic [num_chan_p-1:0] elig;
  logic [num_chan_p-1:0] grant;
  logic                  grant_v;
  logic [PtrW-1:0]       grant_idx;
  logic                  load_ok;
  int unsigned           idx;

  always_comb begin
    for (int unsigned k = 0; k < num_chan_p; k++) begin
      elig[k] = ch_v_i[k] && (cnt_q[k] != '0);
    end
  end

  assign load_ok = (state_q == StEmpty) || yumi_i;

  // Search starts at the pointer and wraps; first eligible channel wins.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned i = 0; i < num_chan_p; i++) begin
      idx = (32'(ptr_q) + i) % num_chan_p;
      if (!grant_v && elig[idx]) begin
        grant_v   = 1'b1;
        grant_idx = PtrW'(idx);
      end
    end
    if (!load_ok || reset_i) begin
      grant_v = 1'b0;
    end
    grant = '0;
    if (grant_v) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    if (grant_v) begin
      state_d = StFull;
      data_d  = ch_data_i[grant_idx*ring_width_p +: ring_width_p];
      ptr_d   = (grant_idx == PtrLast) ? '0 : grant_idx + PtrW'(1);
    end else if ((state_q == StFull) && yumi_i) begin
      state_d = StEmpty;
    end
    // A grant and a returned credit in the same cycle cancel out.
    for (int unsigned k = 0; k < num_chan_p; k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant[k] && !credit_v_i[k]) begin
        cnt_d[k] = cnt_q[k] - CntW'(1);
      end else if (credit_v_i[k] && !grant[k]) begin
        if (cnt_q[k] == CntMax) begin
          err_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < num_chan_p; k++) begin
        cnt_q[k] <= CntMax;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int unsigned k = 0; k < num_chan_p; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Payload needs no reset: it is only observed while v_o is high.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign v_o          = (state_q == StFull);
  assign data_o       = data_q;
  assign ch_yumi_o    = grant;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_bsg_manycore_fsb_tx_sched.sv
// Randomised and directed bench for the FSB transmit scheduler, checked
// against a cycle-level behavioural model of channels, credits and the ring.
module tb_bsg_manycore_fsb_tx_sched;

  localparam int N = 4;
  localparam int W = 80;
  localparam int C = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i;
  logic [N-1:0]   ch_v_i, credit_v_i, ch_yumi_o;
  logic [N*W-1:0] ch_data_i;
  logic           yumi_i, v_o, credit_err_o;
  logic [W-1:0]   data_o;

  bsg_manycore_fsb_tx_sched #(
    .ring_width_p    (W),
    .num_chan_p      (N),
    .remote_credits_p(C)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .ch_v_i      (ch_v_i),
    .ch_data_i   (ch_data_i),
    .ch_yumi_o   (ch_yumi_o),
    .credit_v_i  (credit_v_i),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .credit_err_o(credit_err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int       m_cnt[N];
  int       m_ptr;
  bit       m_full;
  logic [W-1:0] m_data;
  bit       m_err;
  int       exp_g;

  function automatic logic [W-1:0] rand_pkt();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic logic [N*W-1:0] rand_all();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = rand_pkt();
    return d;
  endfunction

  function automatic logic [N-1:0] exp_mask();
    logic [N-1:0] m;
    m = '0;
    if (exp_g >= 0) m[exp_g] = 1'b1;
    return m;
  endfunction

  // Which channel the rules say is granted with the current inputs.
  task automatic model_comb();
    exp_g = -1;
    if (!reset_i && (!m_full || yumi_i)) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (exp_g < 0 && ch_v_i[k] && m_cnt[k] > 0) exp_g = k;
      end
    end
  endtask

  // Clock edge: apply the model update, then return at the next negedge.
  task automatic advance();
    @(posedge clk);
    if (reset_i) begin
      m_full = 0; m_ptr = 0; m_err = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = C;
    end else begin
      if (exp_g >= 0) begin
        m_full = 1;
        m_data = ch_data_i[exp_g*W +: W];
        m_ptr  = (exp_g + 1) % N;
      end else if (m_full && yumi_i) begin
        m_full = 0;
      end
      for (int k = 0; k < N; k++) begin
        if (exp_g == k && !credit_v_i[k]) m_cnt[k] = m_cnt[k] - 1;
        else if (credit_v_i[k] && exp_g != k) begin
          if (m_cnt[k] == C) m_err = 1;
          else m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1; ch_v_i = '0; credit_v_i = '0; yumi_i = 0; ch_data_i = rand_all();
    #1; model_comb(); advance();
    reset_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1; ch_v_i = '1; credit_v_i = '0; yumi_i = 1; ch_data_i = rand_all();
    for (int c = 0; c < 2; c++) begin
      #1; model_comb();
      n_checks++;
      if (ch_yumi_o !== '0) $display("FAIL reset_yumi cyc=%0d got=%b want=0000", c, ch_yumi_o);
      else n_pass++;
      advance();
    end
    reset_i = 0; ch_v_i = '0; yumi_i = 0;
    #1; model_comb();
    n_checks++;
    if (v_o !== 1'b0) $display("FAIL reset_v got=%b want=0", v_o); else n_pass++;
    n_checks++;
    if (credit_err_o !== 1'b0) $display("FAIL reset_err got=%b want=0", credit_err_o);
    else n_pass++;
    advance();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] prev, want;
    do_reset();
    prev = '0;
    ch_v_i = '1; yumi_i = 1;
    for (int i = 0; i < 12; i++) begin
      credit_v_i = prev; ch_data_i = rand_all();
      #1; model_comb();
      want = 4'b0001 << (i % N);
      n_checks++;
      if (ch_yumi_o !== want) $display("FAIL rr_grant cyc=%0d got=%b want=%b", i, ch_yumi_o, want);
      else n_pass++;
      n_checks++;
      if (v_o !== (i > 0)) $display("FAIL rr_v cyc=%0d got=%b want=%b", i, v_o, (i > 0));
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (data_o !== m_data) $display("FAIL rr_data cyc=%0d got=%h want=%h", i, data_o, m_data);
        else n_pass++;
      end
      prev = ch_yumi_o & want;
      advance();
    end
    credit_v_i = '0;
  endtask

  task automatic test_credit_exhaust();
    int grants;
    do_reset();
    grants = 0;
    ch_v_i = 4'b0100; yumi_i = 1; credit_v_i = '0;
    for (int i = 0; i < 8; i++) begin
      ch_data_i = rand_all();
      #1; model_comb();
      if (ch_yumi_o[2]) grants++;
      n_checks++;
      if (ch_yumi_o !== exp_mask()) $display("FAIL exh_grant cyc=%0d got=%b want=%b", i, ch_yumi_o, exp_mask());
      else n_pass++;
      n_checks++;
      if (v_o !== (i == 1 || i == 2)) $display("FAIL exh_v cyc=%0d got=%b want=%b", i, v_o, (i == 1 || i == 2));
      else n_pass++;
      advance();
    end
    n_checks++;
    if (grants != 2) $display("FAIL exh_count got=%0d want=2", grants); else n_pass++;
  endtask

  // Continues from test_credit_exhaust with channel 2 at zero credits.
  task automatic test_credit_return();
    logic [N-1:0] want;
    for (int i = 0; i < 4; i++) begin
      credit_v_i = (i == 0) ? 4'b0100 : 4'b0000;
      ch_data_i = rand_all();
      #1; model_comb();
      want = (i == 1) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (ch_yumi_o !== want) $display("FAIL ret_grant cyc=%0d got=%b want=%b", i, ch_yumi_o, want);
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (v_o !== 1'b1 || data_o !== m_data)
          $display("FAIL ret_data got=%b/%h want=1/%h", v_o, data_o, m_data);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    do_reset();
    ch_v_i = '1; yumi_i = 0; credit_v_i = '0; ch_data_i = rand_all();
    held = ch_data_i[0 +: W];
    #1; model_comb();
    n_checks++;
    if (ch_yumi_o !== 4'b0001) $display("FAIL stall_first got=%b want=0001", ch_yumi_o);
    else n_pass++;
    advance();
    for (int i = 0; i < 5; i++) begin
      ch_data_i = rand_all();
      #1; model_comb();
      n_checks++;
      if (ch_yumi_o !== '0) $display("FAIL stall_yumi cyc=%0d got=%b want=0000", i, ch_yumi_o);
      else n_pass++;
      n_checks++;
      if (v_o !== 1'b1 || data_o !== held)
        $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", i, v_o, data_o, held);
      else n_pass++;
      advance();
    end
    yumi_i = 1; ch_data_i = rand_all();
    #1; model_comb();
    n_checks++;
    if (ch_yumi_o !== 4'b0010) $display("FAIL stall_release got=%b want=0010", ch_yumi_o);
    else n_pass++;
    advance();
    #1; model_comb();
    n_checks++;
    if (data_o !== m_data) $display("FAIL stall_refill got=%h want=%h", data_o, m_data);
    else n_pass++;
    advance();
  endtask

  task automatic test_overflow();
    int grants;
    do_reset();
    credit_v_i = 4'b0010;
    #1; model_comb();
    n_checks++;
    if (credit_err_o !== 1'b0) $display("FAIL ovf_pre got=%b want=0", credit_err_o);
    else n_pass++;
    advance();
    credit_v_i = '0;
    grants = 0;
    ch_v_i = 4'b0010; yumi_i = 1;
    for (int i = 0; i < 5; i++) begin
      ch_data_i = rand_all();
      #1; model_comb();
      if (ch_yumi_o[1]) grants++;
      n_checks++;
      if (credit_err_o !== 1'b1) $display("FAIL ovf_sticky cyc=%0d got=%b want=1", i, credit_err_o);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (grants != 2) $display("FAIL ovf_sat got=%0d grants want=2", grants); else n_pass++;
    do_reset();
    #1; model_comb();
    n_checks++;
    if (credit_err_o !== 1'b0) $display("FAIL ovf_clear got=%b want=0", credit_err_o);
    else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid();
    int per_ch[N];
    do_reset();
    ch_data_i = rand_all();
    ch_data_i[3*W +: W] = 80'hABC;
    ch_v_i = 4'b1000; yumi_i = 0;
    #1; model_comb();
    n_checks++;
    if (ch_yumi_o !== 4'b1000) $display("FAIL mid_grant got=%b want=1000", ch_yumi_o);
    else n_pass++;
    advance();
    ch_v_i = '0;
    #1; model_comb();
    n_checks++;
    if (v_o !== 1'b1 || data_o !== 80'hABC) $display("FAIL mid_held got=%b/%h want=1/abc", v_o, data_o);
    else n_pass++;
    reset_i = 1;
    #1; model_comb();
    advance();
    reset_i = 0;
    #1; model_comb();
    n_checks++;
    if (v_o !== 1'b0) $display("FAIL mid_v got=%b want=0", v_o); else n_pass++;
    for (int k = 0; k < N; k++) per_ch[k] = 0;
    ch_v_i = '1; yumi_i = 1;
    for (int i = 0; i < 10; i++) begin
      ch_data_i = rand_all();
      #1; model_comb();
      for (int k = 0; k < N; k++) if (ch_yumi_o[k]) per_ch[k]++;
      if (v_o === 1'b1) begin
        n_checks++;
        if (data_o === 80'hABC) $display("FAIL mid_stale cyc=%0d got=%h want!=abc", i, data_o);
        else n_pass++;
      end
      advance();
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (per_ch[k] != C) $display("FAIL mid_credits ch=%0d got=%0d want=%0d", k, per_ch[k], C);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset_i    = ($urandom_range(0, 49) == 0);
      ch_v_i     = N'($urandom);
      credit_v_i = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      yumi_i     = ($urandom_range(0, 3) != 0);
      ch_data_i  = rand_all();
      #1; model_comb();
      n_checks++;
      if (ch_yumi_o !== exp_mask()) $display("FAIL rnd_grant cyc=%0d got=%b want=%b", i, ch_yumi_o, exp_mask());
      else n_pass++;
      n_checks++;
      if (v_o !== m_full || credit_err_o !== m_err)
        $display("FAIL rnd_flags cyc=%0d got=%b%b want=%b%b", i, v_o, credit_err_o, m_full, m_err);
      else n_pass++;
      if (m_full) begin
        n_checks++;
        if (data_o !== m_data) $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, data_o, m_data);
        else n_pass++;
      end
      advance();
    end
    reset_i = 0;
  endtask

  initial begin
    exp_g = -1; m_full = 0; m_ptr = 0; m_err = 0; m_data = '0;
    for (int k = 0; k < N; k++) m_cnt[k] = C;
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_credit_return();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_fsb_tx_sched.md
BSG_MANYCORE_FSB_TX_SCHED -- requirements
Module: bsg_manycore_fsb_tx_sched

Interface
REQ-001 Parameters SHALL be:
- ring_width_p, "inv": FSB ring packet width.
- num_chan_p, "inv": number of requesting channels, 2..16.
- remote_credits_p, "inv": initial credits per channel, at least 1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: the block's single clock.
- reset_i, in, 1: synchronous, active-high reset.
- ch_v_i, in, num_chan_p: per-channel packet valid.
- ch_data_i, in, num_chan_p*ring_width_p: per-channel packet; channel k occupies bits [k*ring_width_p +: ring_width_p].
- ch_yumi_o, out, num_chan_p: packet consumed from channel k this cycle.
- credit_v_i, in, num_chan_p: one credit returned to channel k this cycle.
- v_o, out, 1: ring output valid.
- data_o, out, ring_width_p: ring output packet.
- yumi_i, in, 1: ring has consumed data_o; may depend on v_o in the same cycle.
- credit_err_o, out, 1: sticky flag for credit overflow.
REQ-003 The block SHALL have one clock, clk_i; reset_i SHALL be synchronous and active-high.

Function
REQ-004 Each channel k SHALL have a credit counter cnt[k] of width clog2(remote_credits_p+1) bits.
REQ-005 Channel k SHALL be eligible when ch_v_i[k]=1 and cnt[k]>0.
REQ-006 The output register SHALL have two states, EMPTY (v_o=0) and FULL (v_o=1).
REQ-007 A load SHALL be permitted when the state is EMPTY, or when the state is FULL and yumi_i=1.
REQ-008 When a load is permitted and at least one channel is eligible, exactly one channel g SHALL be granted.
- ch_yumi_o[g]=1 in that cycle.
- The channel g packet is captured into data_o on the next clock edge.
- The state is FULL after that edge.
REQ-009 At most one ch_yumi_o bit SHALL be high in any cycle; ch_yumi_o SHALL be 0 when no grant occurs.
REQ-010 Grant selection SHALL be round-robin.
- Priority starts at pointer p and proceeds p, p+1, ... num_chan_p-1, 0, ..., p-1.
- After a grant to g, p SHALL become (g+1) mod num_chan_p.
- Without a grant, p SHALL hold.
REQ-011 State transitions SHALL be:
- FULL with yumi_i=1 and no eligible channel goes to EMPTY.
- FULL with yumi_i=1 and a grant stays FULL and holds the new packet (zero-bubble refill).
- FULL with yumi_i=0 holds data_o and v_o unchanged.
REQ-012 Latency from ch_v_i to v_o SHALL be one cycle. Sustained throughput SHALL be one packet per cycle while yumi_i=1 and credits are available.
REQ-013 cnt[k] SHALL update as follows:
- Grant to k and no credit_v_i[k]: decrement by 1.
- credit_v_i[k] and no grant to k: increment by 1.
- Both in the same cycle: unchanged.
REQ-014 A credit that would raise cnt[k] above remote_credits_p SHALL be dropped, with cnt[k] saturated at remote_credits_p, and SHALL set credit_err_o=1 until reset.
REQ-015 A channel with cnt[k]=0 SHALL NOT be granted, even if ch_v_i[k]=1. A credit_v_i[k] arriving in the same cycle SHALL NOT make k eligible until the next cycle.
REQ-016 yumi_i asserted while v_o=0 SHALL be ignored.
REQ-017 ch_data_i of non-granted channels SHALL have no effect. A channel may drop ch_v_i without penalty.

Reset
REQ-018 While reset_i=1 at a clock edge, the next-cycle values SHALL be:
- v_o=0 and state EMPTY.
- p=0.
- cnt[k]=remote_credits_p for all k.
- credit_err_o=0.
REQ-019 While reset_i=1, ch_yumi_o SHALL be all 0; data_o is don't-care while v_o=0.
REQ-020 Reset asserted mid-operation SHALL discard any held packet and any in-flight credit.
- The discarded packet SHALL NOT be presented after reset.
- Credits SHALL be restored to remote_credits_p.

Verification
REQ-021 The bench SHALL use num_chan_p=4, ring_width_p=80, remote_credits_p=2, and SHALL cover these scenarios:
- All four channels valid, yumi_i=1 constantly, credits returned each grant -> grant order 0,1,2,3,0,1,...; v_o=1 every cycle from cycle 1.
- Channel 2 only valid, no credit returns, yumi_i=1 -> exactly 2 grants; then ch_yumi_o[2]=0 indefinitely; v_o drops to 0 after the second packet is consumed.
- Channel 2 at cnt=0; credit_v_i[2] pulsed once -> one further grant to channel 2 starting the cycle after the pulse.
- v_o=1 with yumi_i=0 for 5 cycles and all channels valid -> data_o stable and ch_yumi_o=0 throughout; first grant in the cycle yumi_i rises.
- credit_v_i[1] pulsed at cnt[1]=2 -> cnt[1] stays 2 and credit_err_o=1 from the next cycle until reset.
- Reset asserted while FULL, holding packet 0xABC from channel 3 -> v_o=0 and credits 2/2/2/2 next cycle; 0xABC never appears on data_o.
